// File: rtl/vec3_norm_sequencer.sv
// vec3_norm_sequencer: scales one Q16.16 vec3 to unit length.
// A single fixed-point multiplier is shared by the dot, rsqrt and scale steps.
module vec3_norm_sequencer #(
    parameter int NR_ITERS = 3,
    parameter int FP_FRAC  = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [95:0] in_vec,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [95:0] out_vec,
    output logic        out_zero,
    output logic        out_sat,
    output logic        busy
);

    localparam logic signed [31:0] FP_MAX = 32'sh7fff_ffff;
    localparam logic signed [31:0] FP_MIN = 32'sh8000_0000;
    localparam logic signed [31:0] THREE_HALF = 32'(3 << (FP_FRAC - 1));

    typedef enum logic [3:0] {
        IDLE,
        DOT0,
        DOT1,
        DOT2,
        SEED,
        NR_A,
        NR_B,
        NR_C,
        SCALE0,
        SCALE1,
        SCALE2,
        DONE
    } state_e;

    state_e state_q, state_d;

    logic signed [31:0] vec_q [3];
    logic signed [31:0] vec_d [3];
    logic signed [31:0] out_q [3];
    logic signed [31:0] out_d [3];
    logic signed [31:0] s_q, s_d;
    logic signed [31:0] y_q, y_d;
    logic signed [31:0] t_q, t_d;
    logic [2:0]         it_q, it_d;
    logic               zero_q, zero_d;
    logic               sat_q, sat_d;

    logic signed [31:0] mul_a, mul_b, mul_p;
    logic signed [63:0] mul_full, mul_shr;
    logic               mul_ovf;
    logic signed [31:0] nr_fac;
    logic signed [31:0] seed;
    int                 msb;
    int                 half_e;

    function automatic logic signed [31:0] sat_add(
        input logic signed [31:0] a,
        input logic signed [31:0] b
    );
        logic [32:0] sum;
        sum = {a[31], a} + {b[31], b};
        if (sum[32] != sum[31]) begin
            return sum[32] ? FP_MIN : FP_MAX;
        end
        return sum[31:0];
    endfunction

    function automatic logic add_ovf(
        input logic signed [31:0] a,
        input logic signed [31:0] b
    );
        logic [32:0] sum;
        sum = {a[31], a} + {b[31], b};
        return sum[32] != sum[31];
    endfunction

    // Shared multiplier: floor((a*b) >> FP_FRAC), clamped to the fp range
    always_comb begin
        mul_full = 64'(mul_a) * 64'(mul_b);
        mul_shr  = mul_full >>> FP_FRAC;
        mul_ovf  = mul_shr[63:31] != {33{mul_shr[63]}};
        if (mul_ovf) begin
            mul_p = mul_shr[63] ? FP_MIN : FP_MAX;
        end else begin
            mul_p = mul_shr[31:0];
        end
    end

    // Initial rsqrt guess 2^-ceil(e/2) from the MSB position of s
    always_comb begin
        msb = 0;
        for (int i = 0; i < 31; i++) begin
            if (s_q[i]) begin
                msb = i;
            end
        end
        half_e = (msb - FP_FRAC + 1) >>> 1;
        seed   = 32'd1 << (FP_FRAC - half_e);
    end

    // Newton-Raphson correction factor 1.5 - t/2
    always_comb begin
        nr_fac = sat_add(THREE_HALF, -(t_q >>> 1));
    end

    // Multiplier operand routing by sequencer step
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        unique case (state_q)
            DOT0: begin
                mul_a = vec_q[0];
                mul_b = vec_q[0];
            end
            DOT1: begin
                mul_a = vec_q[1];
                mul_b = vec_q[1];
            end
            DOT2: begin
                mul_a = vec_q[2];
                mul_b = vec_q[2];
            end
            NR_A: begin
                mul_a = y_q;
                mul_b = y_q;
            end
            NR_B: begin
                mul_a = s_q;
                mul_b = t_q;
            end
            NR_C: begin
                mul_a = y_q;
                mul_b = nr_fac;
            end
            SCALE0: begin
                mul_a = vec_q[0];
                mul_b = y_q;
            end
            SCALE1: begin
                mul_a = vec_q[1];
                mul_b = y_q;
            end
            SCALE2: begin
                mul_a = vec_q[2];
                mul_b = y_q;
            end
            default: begin
                mul_a = '0;
                mul_b = '0;
            end
        endcase
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        out_d   = out_q;
        s_d     = s_q;
        y_d     = y_q;
        t_d     = t_q;
        it_d    = it_q;
        zero_d  = zero_q;
        sat_d   = sat_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    vec_d[0] = in_vec[95:64];
                    vec_d[1] = in_vec[63:32];
                    vec_d[2] = in_vec[31:0];
                    s_d      = '0;
                    it_d     = '0;
                    zero_d   = 1'b0;
                    sat_d    = 1'b0;
                    state_d  = DOT0;
                end
            end
            DOT0, DOT1, DOT2: begin
                s_d = sat_add(s_q, mul_p);
                if (mul_ovf || add_ovf(s_q, mul_p)) begin
                    sat_d = 1'b1;
                end
                if (state_q == DOT0) begin
                    state_d = DOT1;
                end else if (state_q == DOT1) begin
                    state_d = DOT2;
                end else if (s_d == '0) begin
                    out_d   = '{default: '0};
                    zero_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = SEED;
                end
            end
            SEED: begin
                y_d     = seed;
                state_d = NR_A;
            end
            NR_A: begin
                t_d     = mul_p;
                state_d = NR_B;
            end
            NR_B: begin
                t_d     = mul_p;
                state_d = NR_C;
            end
            NR_C: begin
                y_d = mul_p;
                if (it_q == 3'(NR_ITERS - 1)) begin
                    state_d = SCALE0;
                end else begin
                    it_d    = it_q + 3'd1;
                    state_d = NR_A;
                end
            end
            SCALE0: begin
                out_d[0] = mul_p;
                state_d  = SCALE1;
            end
            SCALE1: begin
                out_d[1] = mul_p;
                state_d  = SCALE2;
            end
            SCALE2: begin
                out_d[2] = mul_p;
                state_d  = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            vec_q   <= '{default: '0};
            out_q   <= '{default: '0};
            s_q     <= '0;
            y_q     <= '0;
            t_q     <= '0;
            it_q    <= '0;
            zero_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            out_q   <= out_d;
            s_q     <= s_d;
            y_q     <= y_d;
            t_q     <= t_d;
            it_q    <= it_d;
            zero_q  <= zero_d;
            sat_q   <= sat_d;
        end
    end

    assign in_ready  = state_q == IDLE;
    assign busy      = state_q != IDLE;
    assign out_valid = state_q == DONE;
    assign out_vec   = {out_q[0], out_q[1], out_q[2]};
    assign out_zero  = zero_q;
    assign out_sat   = sat_q;

endmodule

// File: tb/tb_vec3_norm_sequencer.sv
// tb_vec3_norm_sequencer: scoreboard bench for the vec3 normaliser.
// Expected vectors come from a real-valued model of exact normalisation.
module tb_vec3_norm_sequencer;

    localparam int NR_ITERS = 3;
    localparam int TOL = 64;
    localparam int ONE = 65536;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [95:0] in_vec = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [95:0] out_vec;
    logic        out_zero;
    logic        out_sat;
    logic        busy;

    vec3_norm_sequencer #(
        .NR_ITERS(NR_ITERS),
        .FP_FRAC (16)
    ) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_vec   (in_vec),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_vec  (out_vec),
        .out_zero (out_zero),
        .out_sat  (out_sat),
        .busy     (busy)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int x;
        int y;
        int z;
        bit zero;
        bit sat;
        bit vec_ok;
        int acc;
        int lat;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   hs_cnt = 0;
    bit   ov_prev = 1'b0;

    task automatic check(input string tag, input longint got,
                         input longint exp, input longint tol);
        tests++;
        if (got - exp > tol || exp - got > tol) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d (tol %0d)",
                     tag, got, exp, tol);
        end
    endtask

    function automatic int fx(input real r);
        return $rtoi(r * 65536.0 + (r >= 0.0 ? 0.5 : -0.5));
    endfunction

    function automatic exp_t model(input int x, input int y,
                                   input int z, input int acc);
        exp_t e;
        real rx, ry, rz, ss, n;
        rx = x / 65536.0;
        ry = y / 65536.0;
        rz = z / 65536.0;
        ss = rx * rx + ry * ry + rz * rz;
        e.acc = acc;
        if (x == 0 && y == 0 && z == 0) begin
            e.x = 0; e.y = 0; e.z = 0;
            e.zero = 1'b1;
            e.sat = 1'b0;
            e.vec_ok = 1'b1;
            e.lat = 4;
        end else begin
            n = $sqrt(ss);
            e.x = fx(rx / n);
            e.y = fx(ry / n);
            e.z = fx(rz / n);
            e.zero = 1'b0;
            e.sat = ss >= 32768.0;
            e.vec_ok = !e.sat;
            e.lat = 8 + 3 * NR_ITERS;
        end
        return e;
    endfunction

    always @(posedge clk_in) cyc++;

    // Output monitor: latency on first valid, contents on handshake
    always @(negedge clk_in) begin
        if (rst_in) begin
            ov_prev = 1'b0;
        end else begin
            if (out_valid && !ov_prev) begin
                if (sbq.size() == 0) check("spurious_valid", 1, 0, 0);
                else check("latency", cyc - sbq[0].acc, sbq[0].lat, 0);
            end
            if (out_valid && out_ready) begin
                hs_cnt++;
                if (sbq.size() != 0) begin
                    mon_e = sbq.pop_front();
                    if (mon_e.vec_ok) begin
                        check("out_x", longint'($signed(out_vec[95:64])),
                              mon_e.x, TOL);
                        check("out_y", longint'($signed(out_vec[63:32])),
                              mon_e.y, TOL);
                        check("out_z", longint'($signed(out_vec[31:0])),
                              mon_e.z, TOL);
                    end
                    check("out_zero", out_zero, mon_e.zero, 0);
                    check("out_sat", out_sat, mon_e.sat, 0);
                end
            end
            ov_prev = out_valid;
        end
    end

    task automatic send(input int x, input int y, input int z);
        int n = 0;
        in_vec   = {32'(x), 32'(y), 32'(z)};
        in_valid = 1'b1;
        @(negedge clk_in);
        while (!in_ready && n < 200) begin
            @(negedge clk_in);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 0, 1, 0);
        end else begin
            sbq.push_back(model(x, y, z, cyc));
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sbq.size() != 0 || !in_ready) && n < 300) begin
            @(negedge clk_in);
            n++;
        end
        check("drain_timeout", n < 300, 1, 0);
        @(posedge clk_in);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_valid"}, out_valid, 0, 0);
        check({tag, "_vec"}, out_vec == '0, 1, 0);
        check({tag, "_ready"}, in_ready, 1, 0);
        check({tag, "_busy"}, busy, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int h0;
        int n;
        logic [95:0] snap;
        int rx, ry, rz;

        repeat (3) @(posedge clk_in);
        #1;
        check_reset_vals("rst");
        rst_in = 1'b0;
        @(posedge clk_in);
        #1;

        send(3 * ONE, 4 * ONE, 0);
        in_valid = 1'b0;
        wait_drain();
        send(-2 * ONE, -2 * ONE, -1 * ONE);
        in_valid = 1'b0;
        wait_drain();
        send(ONE, 0, 0);
        in_valid = 1'b0;
        wait_drain();
        send(0, 0, 0);
        in_valid = 1'b0;
        wait_drain();
        send(200 * ONE, 200 * ONE, 0);
        in_valid = 1'b0;
        wait_drain();
        send(ONE, 2 * ONE, -2 * ONE);
        in_valid = 1'b0;
        wait_drain();

        // backpressure
        out_ready = 1'b0;
        send(3 * ONE, 0, 4 * ONE);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk_in);
            n++;
        end
        check("bp_valid_seen", out_valid, 1, 0);
        snap = out_vec;
        in_vec = {32'(7 * ONE), 32'(ONE), 32'(ONE)};
        in_valid = 1'b1;
        repeat (10) begin
            @(negedge clk_in);
            check("bp_vec_hold", out_vec == snap, 1, 0);
            check("bp_in_ready", in_ready, 0, 0);
            check("bp_valid_hold", out_valid, 1, 0);
        end
        @(posedge clk_in);
        #1;
        in_valid = 1'b0;
        h0 = hs_cnt;
        out_ready = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in);
        check("bp_ready_after", in_ready, 1, 0);
        check("bp_valid_after", out_valid, 0, 0);
        repeat (5) @(negedge clk_in);
        check("bp_one_hs", hs_cnt - h0, 1, 0);
        @(posedge clk_in);
        #1;

        // reset in the middle of the NR iterations
        h0 = hs_cnt;
        send(ONE, ONE, ONE);
        in_valid = 1'b0;
        repeat (6) @(posedge clk_in);
        #1;
        check("mid_busy", busy, 1, 0);
        rst_in = 1'b1;
        #1;
        check_reset_vals("midrst");
        sbq.delete();
        repeat (3) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        repeat (30) @(negedge clk_in);
        check("midrst_no_out", hs_cnt - h0, 0, 0);
        @(posedge clk_in);
        #1;

        // back-to-back random vectors
        h0 = hs_cnt;
        for (int i = 0; i < 4; i++) begin
            rx = int'($urandom_range(8 * ONE, ONE));
            if ($urandom_range(1, 0) == 1) rx = -rx;
            ry = int'($urandom_range(16 * ONE, 0)) - 8 * ONE;
            rz = int'($urandom_range(16 * ONE, 0)) - 8 * ONE;
            send(rx, ry, rz);
        end
        in_valid = 1'b0;
        wait_drain();
        check("b2b_count", hs_cnt - h0, 4, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
